// File: rtl/tilt_pkg.sv
// Shared types for the tilt acquisition path: sample type used by the
// sequencer and the position remapper, plus the sequencer state encoding.
package tilt_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_REQ       = 2'd2,
    ST_PUBLISH   = 2'd3
  } state_t;

endpackage

// File: rtl/tilt_interval_timer.sv
// Sample-interval tick generator: counts 0..TICK_DIV-1 while enabled and
// strobes tick on the last count; held at zero while disabled.
module tilt_interval_timer #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/tilt_sample_sequencer.sv
// Periodic req/ack acquisition of tilt samples with boxcar averaging over
// 2^AVG_LOG2 samples and a sticky handshake-timeout flag.
//
//   state        | meaning
//   ST_IDLE      | disabled, nothing pending
//   ST_WAIT_TICK | waiting for the next sample interval tick
//   ST_REQ       | smp_req high, waiting for ack or timeout
//   ST_PUBLISH   | full set accumulated, load average and strobe valid
module tilt_sample_sequencer
  import tilt_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int AVG_LOG2 = 3,
  parameter int TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        smp_req,
  input  logic        smp_ack,
  input  logic [15:0] smp_data,
  output logic [15:0] avg_out,
  output logic        avg_valid,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic                     tick;
  logic                     ack_ok;
  logic                     to_hit;
  sample_t                  sample;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         smp_cnt;
  logic [TO_W-1:0]          to_cnt;
  sample_t                  avg_q;
  logic                     avg_valid_q;
  logic                     err_q;

  tilt_interval_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  assign sample = sample_t'(smp_data);

  // An ack in the limit cycle wins over the timeout.
  assign ack_ok = enable && (state == ST_REQ) && smp_ack;
  assign to_hit = enable && (state == ST_REQ) && !smp_ack && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      state_nxt = ST_WAIT_TICK;
        ST_WAIT_TICK: if (tick) state_nxt = ST_REQ;
        ST_REQ: begin
          if (ack_ok) begin
            state_nxt = (smp_cnt == CNT_LAST) ? ST_PUBLISH : ST_WAIT_TICK;
          end else if (to_hit) begin
            state_nxt = ST_WAIT_TICK;
          end
        end
        ST_PUBLISH:   state_nxt = ST_WAIT_TICK;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    smp_req     = (state == ST_REQ);
    avg_valid   = avg_valid_q;
    avg_out     = avg_q;
    timeout_err = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      smp_cnt     <= '0;
      to_cnt      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      avg_valid_q <= 1'b0;
      if (to_hit) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end

      if (!enable) begin
        acc     <= '0;
        smp_cnt <= '0;
        to_cnt  <= '0;
      end else begin
        case (state)
          ST_REQ: begin
            if (ack_ok) begin
              acc     <= acc + ACC_W'(sample);
              smp_cnt <= smp_cnt + CNT_W'(1);
              to_cnt  <= '0;
            end else if (to_hit) begin
              acc     <= '0;
              smp_cnt <= '0;
              to_cnt  <= '0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          // Average and strobe are registered together so they line up.
          ST_PUBLISH: begin
            avg_q       <= sample_t'(acc >>> AVG_LOG2);
            avg_valid_q <= 1'b1;
            acc         <= '0;
            smp_cnt     <= '0;
            to_cnt      <= '0;
          end
          default: to_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tilt_sample_sequencer.sv
// Directed bench for tilt_sample_sequencer with TICK_DIV=4, AVG_LOG2=2,
// TIMEOUT=8; expected averages are hand-computed floor means of each set.
module tb_tilt_sample_sequencer;

  localparam int TICK_DIV = 4;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        smp_ack = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] smp_data = '0;
  logic        smp_req;
  logic [15:0] avg_out;
  logic        avg_valid;
  logic        timeout_err;

  int total = 0;
  int passed = 0;
  int req_rises = 0;
  int valid_pulses = 0;
  logic req_prev = 1'b0;

  tilt_sample_sequencer #(
    .TICK_DIV (TICK_DIV),
    .AVG_LOG2 (AVG_LOG2),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .smp_req     (smp_req),
    .smp_ack     (smp_ack),
    .smp_data    (smp_data),
    .avg_out     (avg_out),
    .avg_valid   (avg_valid),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (smp_req && !req_prev) req_rises++;
    if (avg_valid) valid_pulses++;
    req_prev = smp_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (smp_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_sample(input int val, input string tag);
    bit seen;
    wait_req(seen);
    chk({tag, "_req"}, int'(seen), 1);
    if (seen) begin
      @(negedge clk);
      smp_ack  = 1'b1;
      smp_data = val[15:0];
      @(negedge clk);
      smp_ack  = 1'b0;
    end
  endtask

  task automatic wait_valid(input int exp, input string tag);
    bit seen = 1'b0;
    int avg;
    for (int i = 0; i < 50; i++) begin
      if (avg_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_valid"}, int'(seen), 1);
    avg = $signed(avg_out);
    chk({tag, "_avg"}, avg, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, int'(avg_valid), 0);
  endtask

  task automatic group4(input int v0, input int v1, input int v2, input int v3,
                        input int exp, input string tag);
    do_sample(v0, tag);
    do_sample(v1, tag);
    do_sample(v2, tag);
    do_sample(v3, tag);
    wait_valid(exp, tag);
  endtask

  initial begin
    bit seen;
    int hi;
    int rises0;
    int vp0;
    int avg;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", int'(smp_req), 0);
    avg = $signed(avg_out);
    chk("rst_avg", avg, 0);
    chk("rst_valid", int'(avg_valid), 0);
    chk("rst_err", int'(timeout_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    rises0 = req_rises;
    group4(100, 100, 100, 100, 100, "avg100");
    chk("req_per_avg", req_rises - rises0, 4);
    group4(-1, -2, -3, -4, -3, "neg_floor");
    group4(32767, 32767, 32767, 32767, 32767, "max_pos");
    group4(-32768, -32768, -32768, -32768, -32768, "max_neg");

    // Partial set, then a timeout that must discard it.
    do_sample(1000, "partial");
    do_sample(1000, "partial");
    vp0 = valid_pulses;
    wait_req(seen);
    chk("to_req", int'(seen), 1);
    hi = 0;
    while (smp_req && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    chk("to_len", hi, TIMEOUT);
    chk("to_err_set", int'(timeout_err), 1);
    chk("to_no_valid", valid_pulses - vp0, 0);
    group4(40, 40, 40, 40, 40, "after_to");

    err_clr = 1'b1;
    enable  = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", int'(timeout_err), 0);
    chk("dis_req", int'(smp_req), 0);
    enable = 1'b1;

    // Ack in the last allowed cycle is accepted.
    wait_req(seen);
    chk("lim_req", int'(seen), 1);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("lim_req_high", int'(smp_req), 1);
    smp_ack  = 1'b1;
    smp_data = 16'd8;
    @(negedge clk);
    smp_ack = 1'b0;
    chk("lim_err", int'(timeout_err), 0);
    chk("lim_req_drop", int'(smp_req), 0);
    do_sample(8, "lim");
    do_sample(8, "lim");
    do_sample(8, "lim");
    wait_valid(8, "lim");

    // err_clr in the same cycle as a fresh timeout: set wins.
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    wait_req(seen);
    chk("clr_req", int'(seen), 1);
    repeat (TIMEOUT - 1) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_set_wins", int'(timeout_err), 1);
    chk("clr_req_drop", int'(smp_req), 0);

    // Abort mid-request after two samples; late ack ignored.
    do_sample(500, "abort");
    do_sample(500, "abort");
    wait_req(seen);
    chk("abort_req", int'(seen), 1);
    vp0 = valid_pulses;
    enable = 1'b0;
    @(negedge clk);
    chk("abort_req_drop", int'(smp_req), 0);
    smp_ack  = 1'b1;
    smp_data = 16'd9999;
    @(negedge clk);
    smp_ack = 1'b0;
    @(negedge clk);
    avg = $signed(avg_out);
    chk("abort_avg_hold", avg, 8);
    chk("abort_err_hold", int'(timeout_err), 1);
    chk("abort_no_valid", valid_pulses - vp0, 0);
    enable = 1'b1;
    group4(60, 60, 60, 60, 60, "reenable");

    // Asynchronous reset in the middle of a request.
    group4(200, 200, 200, 200, 200, "pre_rst");
    wait_req(seen);
    chk("rst_mid_req", int'(seen), 1);
    rst_n = 1'b0;
    #1;
    chk("async_req", int'(smp_req), 0);
    avg = $signed(avg_out);
    chk("async_avg", avg, 0);
    chk("async_err", int'(timeout_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    group4(-5, -6, -7, -8, -7, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tilt_sample_sequencer.md
Name: tilt_sample_sequencer

Overview:
Sequences acquisition of signed 16-bit tilt samples from the accelerometer reader and feeds a boxcar-averaged value to the position remapper. The remapper turns that value into the one-hot LED board position.
- Issues periodic sample requests over a req/ack handshake.
- Accumulates 2^AVG_LOG2 samples and publishes their arithmetic-shift average with a one-cycle valid strobe.
- Flags handshake timeouts in a sticky error bit.

Parameters:
TICK_DIV, 50000, sample interval in clk cycles (>=2)
AVG_LOG2, 3, log2 of samples averaged per output (0..6)
TIMEOUT, 1023, max cycles smp_req may stay high without smp_ack (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  run sequencing; low aborts and idles the block
smp_req  out  1  request to accelerometer reader; held until ack or timeout
smp_ack  in  1  one-cycle acknowledge; smp_data valid in the same cycle
smp_data  in  16  signed two's-complement raw sample
avg_out  out  16  signed averaged sample, drives remapper input
avg_valid  out  1  one-cycle pulse when avg_out updates
timeout_err  out  1  sticky: a request timed out
err_clr  in  1  clears timeout_err

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: smp_req=0, avg_out=16'sd0 (centre position), avg_valid=0, timeout_err=0, FSM=IDLE. Tick counter, timeout counter, sample counter and accumulator are all 0.
- Tick counter: free-runs 0..TICK_DIV-1 while enable=1; tick = (count==TICK_DIV-1). Cleared while enable=0.
- FSM states: IDLE, WAIT_TICK, REQ, PUBLISH.
- IDLE: go to WAIT_TICK when enable=1.
- WAIT_TICK: on tick, go to REQ. smp_req rises in the cycle after the tick, registered.
- REQ handshake:
  - smp_req=1 and the timeout counter increments each cycle.
  - On smp_ack=1: capture smp_data sign-extended into the accumulator (acc += sample), increment the sample count, drop smp_req next cycle.
  - If the count reaches 2^AVG_LOG2, go to PUBLISH; otherwise go to WAIT_TICK.
- Ticks during REQ or PUBLISH are dropped, not queued.
- Timeout:
  - If the timeout counter reaches TIMEOUT with no ack, drop smp_req, set timeout_err, and discard the partial accumulation (acc=0, count=0).
  - Then go to WAIT_TICK.
  - An ack arriving in the same cycle as the limit is accepted; no timeout.
- PUBLISH (1 cycle):
  - avg_out <= acc >>> AVG_LOG2 (arithmetic shift, floor rounding).
  - avg_valid=1 for this cycle only; acc and count cleared; go to WAIT_TICK.
- Widths:
  - Accumulator is 16+AVG_LOG2 bits signed; no overflow is possible.
  - The result always fits in 16 bits; no saturation needed.
  - AVG_LOG2=0 makes avg_out the last sample.
- enable=0 in any state:
  - Next cycle: smp_req=0, FSM=IDLE, acc/count/timers cleared.
  - avg_out holds its last value; timeout_err is unaffected.
  - A late ack arriving in IDLE is ignored.
- err_clr clears timeout_err. If a new timeout occurs in the same cycle, set wins.
- Asynchronous reset mid-request drops smp_req immediately.

Decomposition:
- Shared package (tilt_pkg): FSM state enum; SAMPLE_W=16; the signed sample typedef shared with the remapper.
- One natural sub-module: tilt_interval_timer, the tick counter with enable-synchronous clear, parameterised by TICK_DIV.
- Accumulator and FSM stay in the top module.

Test Plan:
- TICK_DIV=4, AVG_LOG2=2, ack 1 cycle after each req, samples 100,100,100,100 -> one avg_valid pulse, avg_out=100; smp_req count between pulses = 4.
- Same config, samples -1,-2,-3,-4 -> sum -10, avg_out=-3 (floor). Samples 32767 x4 -> 32767; -32768 x4 -> -32768.
- Timeout: TIMEOUT=8, no ack -> smp_req drops after 8 high cycles, timeout_err=1, no avg_valid. The next 4 acked samples of 40 -> avg_out=40, proving the partial accumulation was discarded.
- Ack exactly on cycle 8 with TIMEOUT=8 -> sample accepted, timeout_err stays 0. Then err_clr asserted together with a fresh timeout -> timeout_err remains 1.
- enable dropped while smp_req=1 after 2 accumulated samples -> smp_req=0 next cycle, a late ack is ignored, avg_out unchanged. After re-enable, 4 fresh samples are needed before avg_valid.
- rst_n pulsed low mid-REQ with avg_out=200 -> immediately smp_req=0, avg_out=0, timeout_err=0. Sequencing restarts cleanly after release.
